// File: rtl/jacobi_eigen_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : jacobi_eigen_ctrl
// Purpose  : Jacobi eigendecomposition sequencer for an N x N symmetric
//            matrix. Accepts a matrix, scans the upper triangle for the
//            largest off-diagonal pivot, and hands rotations to an external
//            rotation engine. It stops on a tolerance or an iteration cap and
//            returns diag(A), V, the rotation count and a status code.
// Options  : EIGEN_ABORT_EN adds an 'abort' input (status 10 on abort).
// Revision : 1.0 - initial release
// ============================================================================
module jacobi_eigen_ctrl #(
  parameter  int WIDTH  = 16,
  parameter  int N      = 4,
  parameter  int ITER_W = 8,
  localparam int IDX_W  = (N > 1) ? $clog2(N) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N*N*WIDTH-1:0]   in_matrix,
  input  logic [WIDTH-1:0]       tol,
  input  logic [ITER_W-1:0]      max_iter,
`ifdef EIGEN_ABORT_EN
  input  logic                   abort,
`endif
  output logic                   rot_valid,
  input  logic                   rot_ready,
  output logic [IDX_W-1:0]       rot_p,
  output logic [IDX_W-1:0]       rot_q,
  output logic [N*N*WIDTH-1:0]   rot_a,
  output logic [N*N*WIDTH-1:0]   rot_v,
  input  logic                   res_valid,
  input  logic [N*N*WIDTH-1:0]   res_a,
  input  logic [N*N*WIDTH-1:0]   res_v,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [N*WIDTH-1:0]     out_values,
  output logic [N*N*WIDTH-1:0]   out_vectors,
  output logic [ITER_W-1:0]      out_iters,
  output logic [1:0]             out_status
);

  localparam int MW    = N * N * WIDTH;
  localparam int P     = N * (N - 1) / 2;
  localparam int CNT_W = (P > 0) ? $clog2(P + 1) : 1;

  localparam logic [WIDTH-1:0] ABS_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] NEG_MIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ONE_Q   = WIDTH'(1) << (WIDTH / 2);

  localparam logic [1:0] ST_CONV = 2'b00;
  localparam logic [1:0] ST_CAP  = 2'b01;
`ifdef EIGEN_ABORT_EN
  localparam logic [1:0] ST_ABORT = 2'b10;
`endif

  // Identity in Q(WIDTH/2): one on every diagonal element.
  function automatic logic [MW-1:0] ident_f();
    logic [MW-1:0] m;
    m = '0;
    for (int i = 0; i < N; i++) begin
      m[(i*N+i)*WIDTH +: WIDTH] = ONE_Q;
    end
    return m;
  endfunction

  localparam logic [MW-1:0] IDENT = ident_f();

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SCAN  = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t             state_q;
  logic               in_ready_q;
  logic [MW-1:0]      a_q;
  logic [MW-1:0]      v_q;
  logic [WIDTH-1:0]   tol_q;
  logic [ITER_W-1:0]  max_iter_q;
  logic [ITER_W-1:0]  iter_q;
  logic               rot_valid_q;
  logic [IDX_W-1:0]   rot_p_q;
  logic [IDX_W-1:0]   rot_q_q;
  logic               out_valid_q;
  logic [1:0]         status_q;

  // Pivot scan bookkeeping
  logic [IDX_W-1:0]   scan_p_q;
  logic [IDX_W-1:0]   scan_q_q;
  logic [CNT_W-1:0]   scan_cnt_q;
  logic [WIDTH-1:0]   max_q;
  logic [IDX_W-1:0]   best_p_q;
  logic [IDX_W-1:0]   best_q_q;

  logic [WIDTH-1:0]   a_el [N][N];
  logic [WIDTH-1:0]   scan_el_d;
  logic [WIDTH-1:0]   scan_abs_d;
  logic               scan_done_d;

  // Element view of the working matrix, row-major packing.
  for (genvar r = 0; r < N; r++) begin : g_row
    for (genvar c = 0; c < N; c++) begin : g_col
      assign a_el[r][c] = a_q[(r*N+c)*WIDTH +: WIDTH];
    end
  end

  // Eigenvalue outputs are the diagonal of the working matrix.
  for (genvar i = 0; i < N; i++) begin : g_diag
    assign out_values[i*WIDTH +: WIDTH] = a_q[(i*N+i)*WIDTH +: WIDTH];
  end

  // Magnitude of the current scan element; the most negative code saturates.
  always_comb begin
    scan_el_d   = a_el[scan_p_q][scan_q_q];
    scan_done_d = (scan_cnt_q == CNT_W'(P));
    if (scan_el_d == NEG_MIN) begin
      scan_abs_d = ABS_MAX;
    end else if (scan_el_d[WIDTH-1]) begin
      scan_abs_d = ~scan_el_d + 1'b1;
    end else begin
      scan_abs_d = scan_el_d;
    end
  end

`ifdef EIGEN_ABORT_EN
  logic abort_hit;
  assign abort_hit = abort &&
                     ((state_q == S_SCAN) || (state_q == S_ISSUE) || (state_q == S_WAIT));
`endif

  // Scan walker: re-armed outside SCAN, visits one upper-triangle pair per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_p_q   <= '0;
      scan_q_q   <= IDX_W'(1);
      scan_cnt_q <= '0;
      max_q      <= '0;
      best_p_q   <= '0;
      best_q_q   <= IDX_W'(1);
    end else if (state_q != S_SCAN) begin
      scan_p_q   <= '0;
      scan_q_q   <= IDX_W'(1);
      scan_cnt_q <= '0;
      max_q      <= '0;
      best_p_q   <= '0;
      best_q_q   <= IDX_W'(1);
    end else if (!scan_done_d) begin
      // Strictly greater keeps the first pair in scan order on ties.
      if (scan_abs_d > max_q) begin
        max_q    <= scan_abs_d;
        best_p_q <= scan_p_q;
        best_q_q <= scan_q_q;
      end
      if (scan_q_q == IDX_W'(N - 1)) begin
        scan_p_q <= scan_p_q + 1'b1;
        scan_q_q <= scan_p_q + IDX_W'(2);
      end else begin
        scan_q_q <= scan_q_q + 1'b1;
      end
      scan_cnt_q <= scan_cnt_q + 1'b1;
    end
  end

  // Main sequencer: handshakes, decision, matrix update and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b0;
      a_q         <= '0;
      v_q         <= '0;
      tol_q       <= '0;
      max_iter_q  <= '0;
      iter_q      <= '0;
      rot_valid_q <= 1'b0;
      rot_p_q     <= '0;
      rot_q_q     <= '0;
      out_valid_q <= 1'b0;
      status_q    <= '0;
`ifdef EIGEN_ABORT_EN
    end else if (abort_hit) begin
      state_q     <= S_DONE;
      rot_valid_q <= 1'b0;
      out_valid_q <= 1'b1;
      status_q    <= ST_ABORT;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid && in_ready_q) begin
            a_q        <= in_matrix;
            v_q        <= IDENT;
            tol_q      <= tol;
            max_iter_q <= max_iter;
            iter_q     <= '0;
            in_ready_q <= 1'b0;
            state_q    <= S_SCAN;
          end else begin
            in_ready_q <= 1'b1;
          end
        end
        S_SCAN: begin
          if (scan_done_d) begin
            if (max_q <= tol_q) begin
              status_q    <= ST_CONV;
              out_valid_q <= 1'b1;
              state_q     <= S_DONE;
            end else if (iter_q == max_iter_q) begin
              status_q    <= ST_CAP;
              out_valid_q <= 1'b1;
              state_q     <= S_DONE;
            end else begin
              rot_p_q     <= best_p_q;
              rot_q_q     <= best_q_q;
              rot_valid_q <= 1'b1;
              state_q     <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          if (rot_ready) begin
            rot_valid_q <= 1'b0;
            state_q     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (res_valid) begin
            a_q <= res_a;
            v_q <= res_v;
            if (iter_q != {ITER_W{1'b1}}) begin
              iter_q <= iter_q + 1'b1;
            end
            state_q <= S_SCAN;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign rot_valid   = rot_valid_q;
  assign rot_p       = rot_p_q;
  assign rot_q       = rot_q_q;
  assign rot_a       = a_q;
  assign rot_v       = v_q;
  assign out_valid   = out_valid_q;
  assign out_vectors = v_q;
  assign out_iters   = iter_q;
  assign out_status  = status_q;

endmodule
`default_nettype wire
